selector_modo: RTL and testbench

- Generates the 2-bit display-mode select `e_mux` that drives the Hamming(7,4) output multiplexer. The codes are: 01 corrected word, 10 received word with error, 11 syndromes, 00 blank.
- Modes change in two ways: a debounced press of a physical push button advances the mode, and an optional auto-scan timer advances it periodically.
- The block sits directly upstream of the output mux, between the board button and the mux select input.

---
 rtl/selector_modo.sv | 107 ++++++++++
 tb/tb_selector_modo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/selector_modo.sv
// Display-mode selector for the Hamming(7,4) output mux: a debounced push
// button and an optional auto-scan timer advance a 4-state mode FSM.
module selector_modo #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int AUTO_CYCLES     = 54000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       auto_en,
  output logic [1:0] e_mux,
  output logic       cambio,
  output logic       btn_estable
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);

  // The state encoding is the mux select code, so e_mux is the state itself.
  typedef enum logic [1:0] {
    APAGADO   = 2'b00,
    CORREGIDO = 2'b01,
    ERROR     = 2'b10,
    SINDROME  = 2'b11
  } modo_t;

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_btn_estable;
  logic          r_btn_estable_d;
  logic [AW-1:0] r_timer;
  modo_t         r_estado;
  logic          r_cambio;

  logic          w_press;
  logic          w_timer_activo;
  logic          w_expira;
  logic          w_avanza;
  modo_t         w_siguiente;

  // Valid/ready does not apply here: w_press is a single-cycle event that is
  // consumed unconditionally by the FSM on the edge after the falling level.
  always_comb begin
    w_press        = r_btn_estable_d & ~r_btn_estable;
    w_timer_activo = auto_en && (r_estado != APAGADO);
    w_expira       = w_timer_activo && (r_timer == AUTO_MAX);
    w_avanza       = w_press || w_expira;
    w_siguiente    = r_estado;
    case (r_estado)
      APAGADO:   w_siguiente = CORREGIDO;
      CORREGIDO: w_siguiente = ERROR;
      ERROR:     w_siguiente = SINDROME;
      SINDROME:  w_siguiente = CORREGIDO;
      default:   w_siguiente = APAGADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1            <= 1'b1;
      r_s2            <= 1'b1;
      r_deb_cnt       <= '0;
      r_btn_estable   <= 1'b1;
      r_btn_estable_d <= 1'b1;
    end else begin
      r_s1            <= btn_n;
      r_s2            <= r_s1;
      r_btn_estable_d <= r_btn_estable;
      if (r_s2 == r_btn_estable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_btn_estable <= r_s2;
        r_deb_cnt     <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= APAGADO;
      r_timer  <= '0;
      r_cambio <= 1'b0;
    end else begin
      r_cambio <= w_avanza;
      if (w_avanza) begin
        r_estado <= w_siguiente;
      end
      // A press or an expiry restarts the period; a simultaneous pair
      // still produces a single advance.
      if (!w_timer_activo || w_avanza) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + AW'(1);
      end
    end
  end

  assign e_mux       = r_estado;
  assign cambio      = r_cambio;
  assign btn_estable = r_btn_estable;

endmodule

// File: tb/tb_selector_modo.sv
// Bench for selector_modo: directed scenarios followed by random button,
// auto_en and reset activity, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_selector_modo;

  localparam int D = 4;
  localparam int A = 10;

  logic       clk;
  logic       rst_n;
  logic       btn_n;
  logic       auto_en;
  logic [1:0] e_mux;
  logic       cambio;
  logic       btn_estable;

  int checks;
  int errors;
  int cambio_cnt;

  // Behavioural model: sample history, disagreement run length, mode and
  // cycles elapsed in the current auto-scan period.
  bit         m_s1, m_s2, m_stable, m_fell, m_cambio;
  int         m_run, m_elapsed;
  logic [1:0] m_mode;

  selector_modo #(.DEBOUNCE_CYCLES(D), .AUTO_CYCLES(A)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .auto_en(auto_en),
    .e_mux(e_mux), .cambio(cambio), .btn_estable(btn_estable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit press;
    bit fire;
    logic [1:0] nm;
    if (!rst_n) begin
      m_s1 = 1; m_s2 = 1; m_stable = 1; m_fell = 0; m_cambio = 0;
      m_run = 0; m_elapsed = 0; m_mode = 2'd0;
    end else begin
      press = m_fell;
      fire  = auto_en && (m_mode != 2'd0) && (m_elapsed == A - 1);
      nm    = m_mode;
      if (press || fire) nm = (m_mode == 2'd3) ? 2'd1 : m_mode + 2'd1;
      if (!auto_en || m_mode == 2'd0 || press || fire) m_elapsed = 0;
      else m_elapsed++;
      m_cambio = (nm != m_mode);
      m_mode   = nm;
      m_fell   = 0;
      if (m_s2 == m_stable) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_stable = m_s2;
          m_run    = 0;
          m_fell   = !m_s2;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (cambio === 1'b1) cambio_cnt++;
    chk("model_e_mux", {6'd0, e_mux}, {6'd0, m_mode});
    chk("model_cambio", {7'd0, cambio}, {7'd0, m_cambio});
    chk("model_btn_estable", {7'd0, btn_estable}, {7'd0, m_stable});
  endtask

  task automatic press();
    btn_n = 1'b0;
    repeat (8) tick();
    btn_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    logic [1:0] wrap_seq [4];
    int hold;
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd1};
    checks = 0; errors = 0; cambio_cnt = 0;
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_fell = 0; m_cambio = 0;
    m_run = 0; m_elapsed = 0; m_mode = 2'd0;
    rst_n = 1'b0; btn_n = 1'b1; auto_en = 1'b0;
    @(negedge clk);

    // Reset, then auto-scan must not leave APAGADO.
    repeat (3) tick();
    chk("reset_e_mux", {6'd0, e_mux}, 8'd0);
    chk("reset_cambio", {7'd0, cambio}, 8'd0);
    chk("reset_btn_estable", {7'd0, btn_estable}, 8'd1);
    rst_n = 1'b1; auto_en = 1'b1;
    repeat (50) tick();
    chk("auto_in_apagado", {6'd0, e_mux}, 8'd0);
    auto_en = 1'b0;

    // Clean press: tick index 0 is the first edge sampling btn_n=0.
    btn_n = 1'b0;
    cambio_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) chk("press_estable_k4", {7'd0, btn_estable}, 8'd1);
      if (i == 5) chk("press_estable_k5", {7'd0, btn_estable}, 8'd0);
      if (i == 5) chk("press_mux_k5", {6'd0, e_mux}, 8'd0);
      if (i == 6) chk("press_mux_k6", {6'd0, e_mux}, 8'd1);
      if (i == 6) chk("press_cambio_k6", {7'd0, cambio}, 8'd1);
      if (i == 7) chk("press_cambio_k7", {7'd0, cambio}, 8'd0);
    end
    btn_n = 1'b1;
    repeat (20) tick();
    chk("release_mux", {6'd0, e_mux}, 8'd1);
    chk("press_pulses", 8'(cambio_cnt), 8'd1);

    // Bounce rejection.
    btn_n = 1'b0; repeat (3) tick();
    btn_n = 1'b1; tick();
    btn_n = 1'b0; repeat (3) tick();
    btn_n = 1'b1; repeat (10) tick();
    chk("bounce_mux", {6'd0, e_mux}, 8'd1);
    chk("bounce_estable", {7'd0, btn_estable}, 8'd1);

    // Wrap from reset.
    rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1;
    cambio_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      press();
      chk("wrap_mux", {6'd0, e_mux}, {6'd0, wrap_seq[p]});
    end
    chk("wrap_pulses", 8'(cambio_cnt), 8'd4);

    // Auto-scan from CORREGIDO.
    auto_en = 1'b1;
    repeat (9) tick();
    chk("auto_before_first", {6'd0, e_mux}, 8'd1);
    tick();
    chk("auto_first", {6'd0, e_mux}, 8'd2);
    repeat (10) tick();
    chk("auto_second", {6'd0, e_mux}, 8'd3);
    repeat (10) tick();
    chk("auto_third", {6'd0, e_mux}, 8'd1);
    repeat (4) tick();
    auto_en = 1'b0; tick();
    auto_en = 1'b1;
    repeat (9) tick();
    chk("auto_restart_hold", {6'd0, e_mux}, 8'd1);
    tick();
    chk("auto_restart_adv", {6'd0, e_mux}, 8'd2);

    // Collision: press action lands on the expiry edge E+10 in state ERROR.
    repeat (3) tick();
    btn_n = 1'b0;
    repeat (6) tick();
    chk("coll_before", {6'd0, e_mux}, 8'd2);
    tick();
    chk("coll_mux", {6'd0, e_mux}, 8'd3);
    chk("coll_cambio", {7'd0, cambio}, 8'd1);
    tick();
    chk("coll_single", {6'd0, e_mux}, 8'd3);
    chk("coll_cambio_low", {7'd0, cambio}, 8'd0);
    btn_n = 1'b1;
    repeat (8) tick();
    chk("coll_hold", {6'd0, e_mux}, 8'd3);
    tick();
    chk("coll_next_auto", {6'd0, e_mux}, 8'd1);

    // Reset during a debounce count.
    auto_en = 1'b0;
    btn_n = 1'b0; repeat (3) tick();
    rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1; btn_n = 1'b1;
    cambio_cnt = 0;
    repeat (20) tick();
    chk("midrst_mux", {6'd0, e_mux}, 8'd0);
    chk("midrst_pulses", 8'(cambio_cnt), 8'd0);
    chk("midrst_estable", {7'd0, btn_estable}, 8'd1);

    // Random activity against the model.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        btn_n = ~btn_n;
        hold  = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
